// File: rtl/divide_reconstruct_if.sv
// -----------------------------------------------------------------------------
// divide_reconstruct_if
//   Handshake and operand/result bundle for divide_reconstruct.
//
//   Parameters:
//     QW - quotient width
//     DW - divisor / remainder width
//
//   Signals:
//     go           - start request (level); the operation launches on release
//     quotient     - multiplier operand                     [QW-1:0]
//     divisor      - multiplicand operand                   [DW-1:0]
//     remainder    - addend                                 [DW-1:0]
//     dividend     - reconstructed result, registered       [QW+DW-1:0]
//     result_valid - high while the result is presented
//     check        - divider-output consistency flag
//
//   Modports:
//     master - drives go/operands, observes the result (bench / requester)
//     slave  - the reconstruct unit
// -----------------------------------------------------------------------------
interface divide_reconstruct_if #(
  parameter int QW = 4,
  parameter int DW = 5
);
  logic               go;
  logic [QW-1:0]      quotient;
  logic [DW-1:0]      divisor;
  logic [DW-1:0]      remainder;
  logic [QW+DW-1:0]   dividend;
  logic               result_valid;
  logic               check;

  modport master (
    output go, quotient, divisor, remainder,
    input  dividend, result_valid, check
  );

  modport slave (
    input  go, quotient, divisor, remainder,
    output dividend, result_valid, check
  );
endinterface

// File: rtl/divide_reconstruct.sv
// -----------------------------------------------------------------------------
// divide_reconstruct
//   Sequential shift-and-add unit that rebuilds a dividend from a divider
//   result: dividend = quotient * divisor + remainder. One multiply
//   iteration per clock, LSB-first over the quotient bits.
//
//   Operation: the operands are captured while go is pressed and the run
//   launches when go is released. QW clocks later the result is shown with
//   result_valid high until go is pressed again.
//
//   Parameters:
//     QW - quotient width and iteration count (default 4)
//     DW - divisor / remainder width          (default 5)
//     Result width RW = QW + DW.
//
//   Ports:
//     clk - system clock, rising edge
//     rst - asynchronous, active-high reset
//     bus - divide_reconstruct_if.slave (go, operands, dividend,
//           result_valid, check)
//
//   Build option:
//     DIVIDE_RECONSTRUCT_CHECK_EN - when defined, check is registered with
//     the result and flags a legal restoring-divider output (divisor != 0,
//     remainder < divisor, result < 2^QW). When undefined, check is tied 0.
// -----------------------------------------------------------------------------
module divide_reconstruct #(
  parameter int QW = 4,
  parameter int DW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  divide_reconstruct_if.slave   bus
);

  localparam int RW = QW + DW;
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(QW - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_LOAD_WAIT,
    S_CYCLE,
    S_DISPLAY
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [QW-1:0]   q;
  logic [RW-1:0]   m;
  logic [RW-1:0]   acc;
  logic [RW-1:0]   acc_sum;
  logic [RW-1:0]   dividend_r;
  logic [CW-1:0]   count;

  logic            ld_value;
  logic            cycle_en;
  logic            ld_result;

  // ---------------------------------------------------------------------------
  // Control: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Control: next state and control strobes
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ld_value   = 1'b0;
    cycle_en   = 1'b0;
    ld_result  = 1'b0;
    case (state)
      S_LOAD: begin
        ld_value = 1'b1;
        if (bus.go) state_next = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        // Operands were captured on the edge that entered this state;
        // anything changed while go is held is ignored.
        if (!bus.go) state_next = S_CYCLE;
      end
      S_CYCLE: begin
        cycle_en = 1'b1;
        if (count == LAST_COUNT) begin
          ld_result  = 1'b1;
          state_next = S_DISPLAY;
        end
      end
      S_DISPLAY: begin
        // Loading here lets a new press restart with the operands present
        // at that press.
        ld_value = 1'b1;
        if (bus.go) state_next = S_LOAD_WAIT;
      end
      default: state_next = S_LOAD;
    endcase
  end

  // Moore output: the reset value of state forces this low immediately.
  assign bus.result_valid = (state == S_DISPLAY);

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Post-add accumulator for the current iteration; the final iteration's
  // value goes straight to the result register.
  assign acc_sum = q[0] ? (acc + m) : acc;

  // NOTE: the datapath is reset along with the FSM so a reset mid-run leaves
  // no partial product or stale result behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      m     <= '0;
      acc   <= '0;
      count <= '0;
    end else if (ld_value) begin
      q     <= bus.quotient;
      m     <= {{QW{1'b0}}, bus.divisor};
      acc   <= {{QW{1'b0}}, bus.remainder};
      count <= '0;
    end else if (cycle_en) begin
      acc   <= acc_sum;
      m     <= m << 1;
      q     <= q >> 1;
      count <= count + CW'(1);
    end
  end

  // Result register: holds through load, wait and the next run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_r <= '0;
    end else if (ld_result) begin
      dividend_r <= acc_sum;
    end
  end

  assign bus.dividend = dividend_r;

  // ---------------------------------------------------------------------------
  // Optional consistency flag
  // ---------------------------------------------------------------------------
`ifdef DIVIDE_RECONSTRUCT_CHECK_EN
  logic operands_ok;
  logic check_r;

  // The divisor/remainder test is taken at load time because m and acc are
  // modified during the run; the range test uses the final sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operands_ok <= 1'b0;
      check_r     <= 1'b0;
    end else begin
      if (ld_value) begin
        operands_ok <= (bus.divisor != '0) && (bus.remainder < bus.divisor);
      end
      if (ld_result) begin
        check_r <= operands_ok && (acc_sum[RW-1:QW] == '0);
      end
    end
  end

  assign bus.check = check_r;
`else
  assign bus.check = 1'b0;
`endif

endmodule

// File: tb/tb_divide_reconstruct.sv
// -----------------------------------------------------------------------------
// tb_divide_reconstruct
//   Directed self-checking bench for divide_reconstruct (QW=4, DW=5).
//   Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_divide_reconstruct;

  localparam int QW = 4;
  localparam int DW = 5;
  localparam int RW = QW + DW;

  logic clk;
  logic rst;

  int tests_run;
  int tests_failed;

  logic [RW-1:0] last_div;

  divide_reconstruct_if #(.QW(QW), .DW(DW)) bus ();

  divide_reconstruct #(.QW(QW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic exp_check(input logic [DW-1:0] d,
                                     input logic [DW-1:0] r,
                                     input logic [RW-1:0] res);
`ifdef DIVIDE_RECONSTRUCT_CHECK_EN
    return (d != '0) && (r < d) && (res < RW'(1 << QW));
`else
    return 1'b0;
`endif
  endfunction

  // Press go for `hold` clocks (optionally changing the quotient to q_alt
  // after the third clock), release, then wait for result_valid. Checks that
  // the previous result holds and result_valid stays low until the new
  // result, that it arrives on the 5th edge after release, and its value.
  task automatic run_op(input string tag,
                        input logic [QW-1:0] qv,
                        input logic [DW-1:0] dv,
                        input logic [DW-1:0] rv,
                        input int hold,
                        input logic [QW-1:0] q_alt,
                        input bit toggle);
    logic [RW-1:0] exp_div;
    bit            hold_ok;
    int            n;
    exp_div = RW'(qv) * RW'(dv) + RW'(rv);
    hold_ok = 1'b1;

    bus.quotient  = qv;
    bus.divisor   = dv;
    bus.remainder = rv;
    bus.go        = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.result_valid !== 1'b0 || bus.dividend !== last_div) hold_ok = 1'b0;
      if (i == 2) bus.quotient = q_alt;
    end
    bus.go = 1'b0;

    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (bus.result_valid === 1'b1) break;
      if (bus.dividend !== last_div) hold_ok = 1'b0;
      if (toggle) bus.go = (n < 4) ? ~bus.go : 1'b0;
    end
    bus.go = 1'b0;

    check({tag, ".hold"},    32'(hold_ok), 32'd1);
    check({tag, ".latency"}, 32'(n),       32'd5);
    check({tag, ".dividend"}, 32'(bus.dividend), 32'(exp_div));
    check({tag, ".check"},   32'(bus.check), 32'(exp_check(dv, rv, exp_div)));
    last_div = exp_div;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    last_div      = '0;
    rst           = 1'b1;
    bus.go        = 1'b0;
    bus.quotient  = '0;
    bus.divisor   = '0;
    bus.remainder = '0;

    // Reset state
    #3;
    check("reset.valid",    32'(bus.result_valid), 32'd0);
    check("reset.dividend", 32'(bus.dividend),     32'd0);
    check("reset.check",    32'(bus.check),        32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 5*3+2 = 17
    run_op("q5d3r2", 4'd5, 5'd3, 5'd2, 2, 4'd5, 1'b0);
    // 15*31+31 = 496, restarted from display
    run_op("q15d31r31", 4'd15, 5'd31, 5'd31, 2, 4'd15, 1'b0);
    // divisor zero: result is the remainder
    run_op("q0d0r7", 4'd0, 5'd0, 5'd7, 2, 4'd0, 1'b0);
    // restart from display; 7 must hold until 3*5+1 = 16 appears
    run_op("q3d5r1", 4'd3, 5'd5, 5'd1, 2, 4'd3, 1'b0);
    // hold go 10 clocks, quotient 2 -> 9 mid-hold: 2*4+0 = 8
    run_op("hold_q2d4r0", 4'd2, 5'd4, 5'd0, 10, 4'd9, 1'b0);

    // Reset during the 2nd S_CYCLE clock
    bus.quotient  = 4'd7;
    bus.divisor   = 5'd9;
    bus.remainder = 5'd3;
    bus.go        = 1'b1;
    tick();
    tick();
    bus.go = 1'b0;
    tick();          // enter S_CYCLE
    tick();          // 2nd S_CYCLE clock
    #2;
    rst = 1'b1;
    #1;
    check("abort.valid",    32'(bus.result_valid), 32'd0);
    check("abort.dividend", 32'(bus.dividend),     32'd0);
    check("abort.check",    32'(bus.check),        32'd0);
    tick();
    rst = 1'b0;
    last_div = '0;
    tick();
    check("abort.idle_valid", 32'(bus.result_valid), 32'd0);

    // 6*2+1 = 13 after the aborted run
    run_op("q6d2r1", 4'd6, 5'd2, 5'd1, 2, 4'd6, 1'b0);
    // go toggled during S_CYCLE: 9*7+3 = 66, same latency
    run_op("toggle_q9d7r3", 4'd9, 5'd7, 5'd3, 2, 4'd9, 1'b1);
    // divisor zero with full-scale quotient: result 31
    run_op("q15d0r31", 4'd15, 5'd0, 5'd31, 3, 4'd15, 1'b0);

    // Result persists in display with go low
    repeat (3) tick();
    check("display.persist_valid", 32'(bus.result_valid), 32'd1);
    check("display.persist_div",   32'(bus.dividend),     32'd31);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
